// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_pkg
// Description : Shared definitions for the memory responder: word width,
//               responder state encodings and sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    localparam int WORD_BITS = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    // Encoding 3 can never be reached; treat it as idle so the FSM recovers.
    function automatic logic [1:0] decode_state(input logic [1:0] s);
        return (s == 2'd3) ? S_IDLE : s;
    endfunction

    // Wait counter width: max(1, clog2(wait_cycles + 1)).
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_if
// Description : Request/response bus between the cache management unit
//               (master) and the memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_resp_if;
    import mem_resp_pkg::*;

    logic                 mem_cs_i;
    logic                 mem_we_i;
    logic [31:0]          mem_addr_i;
    logic [WORD_BITS-1:0] mem_data_i;
    logic [WORD_BITS-1:0] mem_data_o;
    logic                 mem_ack_o;
    logic [1:0]           resp_state;

    modport master (
        output mem_cs_i, mem_we_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_ack_o, resp_state
    );

    modport slave (
        input  mem_cs_i, mem_we_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_ack_o, resp_state
    );

endinterface
`default_nettype wire

// File: rtl/mem_resp_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_ram
// Description : Single-port word array with synchronous write and a
//               registered read port. The array itself is never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_resp_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_we,
    input  wire logic                  i_re,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    output logic      [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array write; contents deliberately survive rst
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read; the output register alone clears on reset and holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp
// Description : Fixed-latency memory responder. Captures a request, waits
//               WAIT_CYCLES busy cycles while select stays high, then
//               performs the array access and pulses ack for one cycle.
//               Back-to-back requests may be captured during the ack cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_WIDTH  = 10
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mem_resp_if.slave   bus
);

    localparam int                 c_CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (WAIT_CYCLES > 0) ? c_CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_req_we;
    logic [ADDR_WIDTH-1:0] r_req_idx;
    logic [WORD_BITS-1:0]  r_req_data;
    logic                  r_ack;

    logic [1:0]            w_state;
    logic [ADDR_WIDTH-1:0] w_in_idx;
    logic                  w_enter_ack;
    logic                  w_op_we;
    logic [ADDR_WIDTH-1:0] w_op_idx;
    logic [WORD_BITS-1:0]  w_op_data;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic                  w_unused_addr;

    assign w_state       = decode_state(r_state);
    assign w_in_idx      = bus.mem_addr_i[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^{bus.mem_addr_i[31:ADDR_WIDTH+2], bus.mem_addr_i[1:0]};

    // With no wait cycles the access happens at the capture edge itself,
    // so the array is fed straight from the bus instead of the request registers.
    if (WAIT_CYCLES == 0) begin : g_zero_wait
        assign w_enter_ack = bus.mem_cs_i && (w_state != S_BUSY);
        assign w_op_we     = bus.mem_we_i;
        assign w_op_idx    = w_in_idx;
        assign w_op_data   = bus.mem_data_i;
    end else begin : g_wait
        assign w_enter_ack = bus.mem_cs_i && (w_state == S_BUSY) && (r_cnt == c_CNT_LAST);
        assign w_op_we     = r_req_we;
        assign w_op_idx    = r_req_idx;
        assign w_op_data   = r_req_data;
    end

    // Reset must cancel a write that would otherwise land on this edge
    assign w_ram_we = !rst && w_enter_ack && w_op_we;
    assign w_ram_re = !rst && w_enter_ack && !w_op_we;

    // Request FSM with registered ack and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_req_we   <= 1'b0;
            r_req_idx  <= '0;
            r_req_data <= '0;
            r_ack      <= 1'b0;
        end else begin
            case (w_state)
                S_BUSY: begin
                    if (!bus.mem_cs_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_ack   <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_ACK;
                        r_cnt   <= '0;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                    if (bus.mem_cs_i) begin
                        r_req_we   <= bus.mem_we_i;
                        r_req_idx  <= w_in_idx;
                        r_req_data <= bus.mem_data_i;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_BUSY;
                            r_ack   <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
            endcase
        end
    end

    mem_resp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (WORD_BITS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_op_idx),
        .i_wdata (w_op_data),
        .o_rdata (bus.mem_data_o)
    );

    assign bus.mem_ack_o  = r_ack;
    assign bus.resp_state = w_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_resp
// Description : Scoreboard bench for mem_resp. Index 0 drives a WAIT_CYCLES=3
//               instance, index 1 a WAIT_CYCLES=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_resp;
    import mem_resp_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        cs    [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic [1:0]  st    [2];
    logic [31:0] last  [2];
    int          waitc [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_resp_if if3();
    mem_resp_if if0();

    assign if3.mem_cs_i   = cs[0];
    assign if3.mem_we_i   = we[0];
    assign if3.mem_addr_i = addr[0];
    assign if3.mem_data_i = wdata[0];
    assign ack[0]         = if3.mem_ack_o;
    assign rdata[0]       = if3.mem_data_o;
    assign st[0]          = if3.resp_state;

    assign if0.mem_cs_i   = cs[1];
    assign if0.mem_we_i   = we[1];
    assign if0.mem_addr_i = addr[1];
    assign if0.mem_data_i = wdata[1];
    assign ack[1]         = if0.mem_ack_o;
    assign rdata[1]       = if0.mem_data_o;
    assign st[1]          = if0.resp_state;

    mem_resp #(.WAIT_CYCLES(3), .ADDR_WIDTH(10)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    mem_resp #(.WAIT_CYCLES(0), .ADDR_WIDTH(10)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no ack within bound, expected an ack (cycle %0d)", name, cyc);
    endtask

    task automatic expect_ack(input int d, input int c, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.data = v;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Scoreboard monitor: every ack cycle must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ack[d] === 1'b1) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("FAIL ack_unexpected[%0d]: got ack at cycle %0d, expected none", d, cyc);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("ack_cycle[%0d]", d), cyc, e.cyc);
                    chk($sformatf("ack_data[%0d]", d), rdata[d], e.data);
                end
            end
        end
    end

    // Single request: hold cs until the ack, optionally disturb inputs while busy
    task automatic op(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                      input logic [31:0] exp_rd, input bit scramble);
        int n;
        @(negedge clk);
        cs[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dat;
        if (!w) last[d] = exp_rd;
        expect_ack(d, cyc + 1 + waitc[d], last[d]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && n == 1 && ack[d] !== 1'b1) begin
                we[d] = ~w; addr[d] = a ^ 32'h4; wdata[d] = ~dat;
            end
        end while (ack[d] !== 1'b1 && n < 32);
        if (ack[d] !== 1'b1) timeout("op_ack");
        cs[d] = 1'b0;
    endtask

    // Burst with cs held high; address advances at each ack
    task automatic burst(input int d, input logic [31:0] base_a, input int cnt, input int spacing,
                         input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3);
        logic [31:0] vals [4];
        int base_c;
        int n;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        @(negedge clk);
        cs[d] = 1'b1; we[d] = 1'b0; addr[d] = base_a;
        base_c = cyc + 1 + waitc[d];
        for (int i = 0; i < cnt; i++) expect_ack(d, base_c + spacing * i, vals[i]);
        for (int i = 0; i < cnt; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ack[d] !== 1'b1 && n < 32);
            if (ack[d] !== 1'b1) timeout("burst_ack");
            if (i < cnt - 1) addr[d] = base_a + 32'(4 * (i + 1));
            else             cs[d] = 1'b0;
        end
        last[d] = vals[cnt-1];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        waitc[0] = 3; waitc[1] = 0;
        for (int d = 0; d < 2; d++) begin
            cs[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; last[d] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", {31'd0, ack[d]}, 32'd0);
            chk("reset_data", rdata[d], 32'd0);
            chk("reset_state", {30'd0, st[d]}, 32'd0);
        end
        rst = 1'b0;

        // WAIT_CYCLES=3: write then read back
        op(0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
        op(0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);

        // Burst of four reads, acks spaced four cycles apart
        op(0, 1'b1, 32'h100, 32'h11, 32'h0, 1'b0);
        op(0, 1'b1, 32'h104, 32'h22, 32'h0, 1'b0);
        op(0, 1'b1, 32'h108, 32'h33, 32'h0, 1'b0);
        op(0, 1'b1, 32'h10C, 32'h44, 32'h0, 1'b0);
        burst(0, 32'h100, 4, 4, 32'h11, 32'h22, 32'h33, 32'h44);
        repeat (8) @(negedge clk);
        chk("burst_drained", 32'(q0.size()), 32'd0);

        // Inputs disturbed while busy must not alter the pending write
        op(0, 1'b1, 32'h84, 32'h0, 32'h0, 1'b0);
        op(0, 1'b1, 32'h80, 32'h12345678, 32'h0, 1'b1);
        op(0, 1'b0, 32'h80, 32'h0, 32'h12345678, 1'b0);
        op(0, 1'b0, 32'h84, 32'h0, 32'h0, 1'b0);

        // Abort after one busy cycle: no ack, no write
        op(0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h5;
        @(negedge clk);
        chk("abort_busy_state", {30'd0, st[0]}, {30'd0, S_BUSY});
        cs[0] = 1'b0;
        @(negedge clk);
        chk("abort_idle_state", {30'd0, st[0]}, {30'd0, S_IDLE});
        repeat (6) @(negedge clk);
        chk("abort_no_ack", 32'(q0.size()), 32'd0);
        op(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Reset during a busy write, with cs still asserted
        op(0, 1'b1, 32'h30, 32'hAAAA, 32'h0, 1'b0);
        op(0, 1'b0, 32'h80, 32'h0, 32'h12345678, 1'b0);
        @(negedge clk);
        cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h77;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ack", {31'd0, ack[0]}, 32'd0);
        chk("midrst_data", rdata[0], 32'd0);
        chk("midrst_state", {30'd0, st[0]}, 32'd0);
        rst = 1'b0; cs[0] = 1'b0; last[0] = 32'h0;
        repeat (6) @(negedge clk);
        op(0, 1'b0, 32'h30, 32'h0, 32'hAAAA, 1'b0);

        // WAIT_CYCLES=0: aliasing and back-to-back acks
        op(1, 1'b1, 32'h0, 32'hCAFE0000, 32'h0, 1'b0);
        op(1, 1'b0, 32'h1000, 32'h0, 32'hCAFE0000, 1'b0);
        op(1, 1'b1, 32'h4, 32'hB, 32'h0, 1'b0);
        op(1, 1'b1, 32'h8, 32'hC, 32'h0, 1'b0);
        burst(1, 32'h0, 3, 1, 32'hCAFE0000, 32'hB, 32'hC, 32'h0);
        repeat (4) @(negedge clk);
        chk("b2b_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
